// File: rtl/barret_sweep_checker.sv
// Sweeps din_a over [START, START+COUNT) and checks a combinational Barrett reducer's dout_r
// against a remainder from a bit-serial restoring divider, counting mismatches.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start after reset
// S_LOAD | seed divider from din_a (din_a already stable for this vector)
// S_DIV  | one restoring-division step per cycle, DIN_W cycles
// S_CMP  | sample dout_r against the golden remainder, advance or finish
// S_DONE | sweep result held until start or rst
module barret_sweep_checker #(
    parameter int Q      = 2447,
    parameter int DIN_W  = 23,
    parameter int DOUT_W = 12,
    parameter int START  = 0,
    parameter int COUNT  = 2447,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [DIN_W-1:0]  din_a,
    input  logic [DOUT_W-1:0] dout_r,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [DIN_W-1:0]  first_err_value
);

    localparam int CNT_W = (DIN_W > 1) ? $clog2(DIN_W) : 1;
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(DIN_W - 1);
    localparam logic [DIN_W-1:0]  START_V  = DIN_W'(START);
    localparam logic [DIN_W-1:0]  LAST_IDX = DIN_W'(COUNT - 1);
    localparam logic [DOUT_W:0]   Q_V      = (DOUT_W + 1)'(Q);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_CMP, S_DONE} state_t;

    state_t state, state_nxt;

    logic [DOUT_W:0]   rem;
    logic [DIN_W-1:0]  shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DIN_W-1:0]  idx;
    logic [DOUT_W:0]   r_shift;
    logic [DOUT_W:0]   rem_step;
    logic              mismatch;
    logic [ERR_W-1:0]  err_inc;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                busy      = 1'b1;
                state_nxt = S_DIV;
            end
            S_DIV: begin
                busy = 1'b1;
                if (bit_cnt == '0) state_nxt = S_CMP;
            end
            S_CMP: begin
                busy      = 1'b1;
                state_nxt = (idx == LAST_IDX) ? S_DONE : S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // rem stays below Q between steps, so its top bit is only live inside a step
    always_comb begin
        r_shift  = {rem[DOUT_W-1:0], shift[DIN_W-1]};
        rem_step = (r_shift >= Q_V) ? (r_shift - Q_V) : r_shift;
        mismatch = ({1'b0, dout_r} != rem);
        err_inc  = (mismatch && (err_count != ERR_MAX)) ? (err_count + 1'b1) : err_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_a           <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_value <= '0;
            idx             <= '0;
            rem             <= '0;
            shift           <= '0;
            bit_cnt         <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        din_a           <= START_V;
                        idx             <= '0;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_value <= '0;
                    end
                end
                S_LOAD: begin
                    rem     <= '0;
                    shift   <= din_a;
                    bit_cnt <= BIT_LAST;
                end
                S_DIV: begin
                    rem     <= rem_step;
                    shift   <= shift << 1;
                    bit_cnt <= bit_cnt - 1'b1;
                end
                S_CMP: begin
                    err_count <= err_inc;
                    if (mismatch && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_value <= din_a;
                    end
                    if (idx == LAST_IDX) begin
                        done <= 1'b1;
                        pass <= (err_inc == '0);
                    end else begin
                        din_a <= din_a + 1'b1;
                        idx   <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_barret_sweep_checker.sv
// Bench for barret_sweep_checker: five instances with different ranges and reducer models,
// checked against remainders and error tallies computed directly with % in the bench.
module tb_barret_sweep_checker;

    localparam int Q       = 2447;
    localparam int DIN_W   = 23;
    localparam int DOUT_W  = 12;
    localparam int VEC_CYC = DIN_W + 2;

    localparam int W_START = 2440, W_COUNT = 16;
    localparam int T_START = 8388607, T_COUNT = 1;
    localparam int S_START = 1000, S_COUNT = 64;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic        fev;
        logic [15:0] err;
        logic [22:0] fval;
        logic [22:0] din;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic rst_v   [5];
    logic start_v [5];

    logic [22:0] din0, din1, din2, din3, din4;
    logic [22:0] fval0, fval1, fval2, fval3, fval4;
    logic [11:0] dout0, dout1, dout2, dout3, dout4;
    logic busy0, busy1, busy2, busy3, busy4;
    logic done0, done1, done2, done3, done4;
    logic pass0, pass1, pass2, pass3, pass4;
    logic fev0, fev1, fev2, fev3, fev4;
    logic [15:0] err0, err1, err2, err3;
    logic [3:0]  err4;

    // reducer models attached to each instance
    logic        wrap_fault_en = 1'b0;
    logic [22:0] wrap_fault_v  = '0;
    logic [11:0] wrap_mask     = '0;
    logic [11:0] top_off       = '0;
    int          sat_seed      = 0;
    int          sat_dens      = 1000000;
    logic [11:0] sat_mask      = '0;

    assign dout0 = 12'(din0 % 23'(Q));
    assign dout1 = 12'(din1 % 23'(Q)) & 12'hFFE;
    assign dout2 = 12'(din2 % 23'(Q)) ^ ((wrap_fault_en && din2 == wrap_fault_v) ? wrap_mask : 12'd0);
    assign dout3 = 12'(din3 % 23'(Q)) - top_off;
    assign dout4 = 12'(din4 % 23'(Q)) ^ ((((int'(din4) + sat_seed) % sat_dens) == 0) ? sat_mask : 12'd0);

    barret_sweep_checker #(.Q(Q), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .START(0), .COUNT(2447), .ERR_W(16)) u_good (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .din_a(din0), .dout_r(dout0), .busy(busy0),
        .done(done0), .pass(pass0), .err_count(err0), .first_err_valid(fev0), .first_err_value(fval0));
    barret_sweep_checker #(.Q(Q), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .START(0), .COUNT(2447), .ERR_W(16)) u_bad (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .din_a(din1), .dout_r(dout1), .busy(busy1),
        .done(done1), .pass(pass1), .err_count(err1), .first_err_valid(fev1), .first_err_value(fval1));
    barret_sweep_checker #(.Q(Q), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .START(W_START), .COUNT(W_COUNT), .ERR_W(16)) u_wrap (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .din_a(din2), .dout_r(dout2), .busy(busy2),
        .done(done2), .pass(pass2), .err_count(err2), .first_err_valid(fev2), .first_err_value(fval2));
    barret_sweep_checker #(.Q(Q), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .START(T_START), .COUNT(T_COUNT), .ERR_W(16)) u_top (
        .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .din_a(din3), .dout_r(dout3), .busy(busy3),
        .done(done3), .pass(pass3), .err_count(err3), .first_err_valid(fev3), .first_err_value(fval3));
    barret_sweep_checker #(.Q(Q), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .START(S_START), .COUNT(S_COUNT), .ERR_W(4)) u_sat (
        .clk(clk), .rst(rst_v[4]), .start(start_v[4]), .din_a(din4), .dout_r(dout4), .busy(busy4),
        .done(done4), .pass(pass4), .err_count(err4), .first_err_valid(fev4), .first_err_value(fval4));

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic obs_t obs(input int id);
        obs_t o;
        case (id)
            0: o = '{busy0, done0, pass0, fev0, err0, fval0, din0};
            1: o = '{busy1, done1, pass1, fev1, err1, fval1, din1};
            2: o = '{busy2, done2, pass2, fev2, err2, fval2, din2};
            3: o = '{busy3, done3, pass3, fev3, err3, fval3, din3};
            default: o = '{busy4, done4, pass4, fev4, 16'(err4), fval4, din4};
        endcase
        return o;
    endfunction

    task automatic chk_reset(input int id, input string tag);
        obs_t o;
        o = obs(id);
        chk({tag, "_din_a"}, o.din, 0);
        chk({tag, "_busy"}, o.busy, 0);
        chk({tag, "_done"}, o.done, 0);
        chk({tag, "_pass"}, o.pass, 0);
        chk({tag, "_err_count"}, o.err, 0);
        chk({tag, "_first_err_valid"}, o.fev, 0);
        chk({tag, "_first_err_value"}, o.fval, 0);
    endtask

    // start pulse, then bounded wait for done; optional stray start pulses while busy
    task automatic run_sweep(input int id, input int count, input string tag, input bit noise);
        int n;
        obs_t o;
        @(negedge clk); start_v[id] = 1'b1;
        @(negedge clk); start_v[id] = 1'b0;
        o = obs(id);
        chk({tag, "_busy_after_start"}, o.busy, 1);
        chk({tag, "_done_cleared"}, o.done, 0);
        n = 1;
        while (!obs(id).done && n < count * VEC_CYC + 50) begin
            start_v[id] = noise && (n < count * VEC_CYC - 3) && ($urandom_range(0, 39) == 0);
            @(negedge clk);
            n++;
        end
        start_v[id] = 1'b0;
        chk({tag, "_latency"}, n, count * VEC_CYC + 1);
        chk({tag, "_busy_at_done"}, obs(id).busy, 0);
    endtask

    initial begin
        if (!(Q >= 2 && Q < 2 ** DOUT_W && 2447 >= 1 && W_START + W_COUNT - 1 <= 2 ** DIN_W - 1 &&
              T_START + T_COUNT - 1 <= 2 ** DIN_W - 1 && S_START + S_COUNT - 1 <= 2 ** DIN_W - 1)) begin
            $display("FAIL param_constraint: parameter set violates range limits");
            $fatal(1, "bad parameters");
        end
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 5; i++) begin
            rst_v[i]   = 1'b1;
            start_v[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) rst_v[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) chk_reset(i, $sformatf("reset%0d", i));

        fork
            begin : t_good
                run_sweep(0, 2447, "good", 1'b1);
                chk("good_pass", pass0, 1);
                chk("good_err_count", err0, 0);
                chk("good_first_err_valid", fev0, 0);
            end

            begin : t_bad
                int n;
                int exp_err;
                int first;
                @(negedge clk); start_v[1] = 1'b1;
                @(negedge clk); start_v[1] = 1'b0;
                n = 0;
                while (din1 != 23'd100 && n < 120 * VEC_CYC) begin
                    @(negedge clk);
                    n++;
                end
                repeat (4) @(negedge clk);
                chk("bad_mid_din_a", din1, 100);
                chk("bad_mid_busy", busy1, 1);
                exp_err = 0;
                for (int v = 0; v < 100; v++) if ((v % Q) % 2 == 1) exp_err++;
                chk("bad_mid_err_count", err1, exp_err);
                chk("bad_mid_first_err_value", fval1, 1);
                rst_v[1] = 1'b1;
                @(negedge clk);
                chk_reset(1, "bad_mid_rst");
                rst_v[1] = 1'b0;
                @(negedge clk);
                chk_reset(1, "bad_after_rst");

                run_sweep(1, 2447, "bad", 1'b0);
                exp_err = 0;
                first   = -1;
                for (int v = 0; v < 2447; v++) begin
                    if ((v % Q) % 2 == 1) begin
                        exp_err++;
                        if (first < 0) first = v;
                    end
                end
                chk("bad_err_count", err1, exp_err);
                chk("bad_err_count_1223", err1, 1223);
                chk("bad_first_err_valid", fev1, 1);
                chk("bad_first_err_value", fval1, first);
                chk("bad_pass", pass1, 0);
                repeat (5) @(negedge clk);
                chk("bad_done_hold", done1, 1);
                chk("bad_err_hold", err1, exp_err);

                @(negedge clk); start_v[1] = 1'b1;
                @(negedge clk); start_v[1] = 1'b0;
                chk("bad_restart_err_count", err1, 0);
                chk("bad_restart_done", done1, 0);
                chk("bad_restart_busy", busy1, 1);
                chk("bad_restart_first_err_valid", fev1, 0);
                chk("bad_restart_din_a", din1, 0);
                rst_v[1] = 1'b1;
                @(negedge clk);
                rst_v[1] = 1'b0;
            end

            begin : t_wrap
                int exp_err;
                int first;
                run_sweep(2, W_COUNT, "wrap_ok", 1'b1);
                chk("wrap_ok_pass", pass2, 1);
                chk("wrap_ok_err_count", err2, 0);
                for (int k = 0; k < 3; k++) begin
                    wrap_fault_en = 1'b1;
                    wrap_fault_v  = 23'(2447 + $urandom_range(0, 8));
                    wrap_mask     = 12'($urandom_range(1, 4095));
                    run_sweep(2, W_COUNT, $sformatf("wrap_bad%0d", k), 1'b1);
                    exp_err = 0;
                    first   = -1;
                    for (int v = W_START; v < W_START + W_COUNT; v++) begin
                        if (v == int'(wrap_fault_v)) begin
                            exp_err++;
                            if (first < 0) first = v;
                        end
                    end
                    chk($sformatf("wrap_bad%0d_err_count", k), err2, exp_err);
                    chk($sformatf("wrap_bad%0d_first_err_value", k), fval2, first);
                    chk($sformatf("wrap_bad%0d_pass", k), pass2, 0);
                end
            end

            begin : t_top
                top_off = 12'd0;
                run_sweep(3, T_COUNT, "top_ok", 1'b0);
                chk("top_ok_golden", 12'(din3 % 23'(Q)), 291);
                chk("top_ok_pass", pass3, 1);
                chk("top_ok_err_count", err3, 0);
                top_off = 12'd1;
                run_sweep(3, T_COUNT, "top_bad", 1'b0);
                chk("top_bad_dout_r", dout3, 290);
                chk("top_bad_err_count", err3, 1);
                chk("top_bad_first_err_valid", fev3, 1);
                chk("top_bad_first_err_value", fval3, T_START);
                chk("top_bad_pass", pass3, 0);
            end

            begin : t_sat
                int nf;
                int first;
                for (int k = 0; k < 3; k++) begin
                    sat_seed = $urandom_range(0, 1000);
                    sat_dens = (k == 0) ? 2 : $urandom_range(2, 6);
                    sat_mask = 12'($urandom_range(1, 4095));
                    run_sweep(4, S_COUNT, $sformatf("sat%0d", k), 1'b1);
                    nf    = 0;
                    first = -1;
                    for (int v = S_START; v < S_START + S_COUNT; v++) begin
                        if (((v + sat_seed) % sat_dens) == 0) begin
                            nf++;
                            if (first < 0) first = v;
                        end
                    end
                    chk($sformatf("sat%0d_err_count", k), err4, (nf > 15) ? 15 : nf);
                    chk($sformatf("sat%0d_first_err_valid", k), fev4, (nf > 0) ? 1 : 0);
                    chk($sformatf("sat%0d_first_err_value", k), fval4, (nf > 0) ? first : 0);
                    chk($sformatf("sat%0d_pass", k), pass4, (nf == 0) ? 1 : 0);
                end
            end
        join

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
